// File: rtl/openmips_minimal_sopc.sv
// openmips_minimal_sopc: minimal MIPS32 system used for instruction-class
// simulation. A 5-stage in-order pipeline (IF, ID, EX, MEM, WB) with a private
// instruction ROM, a 32x32 register file and HI/LO registers. Programs are
// loaded into openmips0.inst_rom0.inst_mem by backdoor; results are observed
// in openmips0.regfile1.regs and openmips0.hilo_reg0.hi_o/lo_o.
//
// Ports (top):
//   clk : single clock, all state updates on the rising edge
//   rst : synchronous reset, active-low (0 = reset)
//
// Build option:
//   OPENMIPS_MOVE_EN : when defined, movn/movz/mfhi/mflo/mthi/mtlo execute;
//                      when undefined they decode as nop and HI/LO stay 0.

// Instruction ROM. Output is forced to a nop while ce is low.
module inst_rom (
    input  logic        ce,
    input  logic [31:0] addr,
    output logic [31:0] inst
);
    logic [31:0] inst_mem [0:1023];
    logic        unused_addr;

    assign inst        = ce ? inst_mem[addr[11:2]] : 32'h0;
    assign unused_addr = ^{addr[31:12], addr[1:0]};
endmodule

// Register file: two read ports with write-through, one write port.
// r0 reads as zero and ignores writes.
module regfile #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [4:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [4:0]        raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [4:0]        raddr2,
    output logic [DATA_W-1:0] rdata2
);
    logic [DATA_W-1:0] regs [0:31];

    always_ff @(posedge clk) begin
        if (we && waddr != 5'd0)
            regs[waddr] <= wdata;
    end

    assign rdata1 = (raddr1 == 5'd0) ? '0 :
                    (we && raddr1 == waddr) ? wdata : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 :
                    (we && raddr2 == waddr) ? wdata : regs[raddr2];
endmodule

// HI/LO special registers with independent write enables.
module hilo_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_hi,
    input  logic              we_lo,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_o <= '0;
            lo_o <= '0;
        end else begin
            if (we_hi) hi_o <= hi_i;
            if (we_lo) lo_o <= lo_i;
        end
    end
endmodule

// Pipeline core. Ports: clk, rst (sync, active-low).
module openmips (
    input  logic clk,
    input  logic rst
);
    typedef enum logic [2:0] {
        ALU_NOP, ALU_OR, ALU_AND, ALU_XOR, ALU_NOR, ALU_PASS, ALU_HI, ALU_LO
    } alu_e;

    logic [31:0] pc, rom_inst, inst_p0;
    logic        vld_p0;
    alu_e        alusel_p1;
    logic [31:0] opa_p1, opb_p1, wdata_p2, hilo_p2, wdata_p3, hilo_p3;
    logic [4:0]  wd_p1, wd_p2, wd_p3;
    logic        wreg_p1, whi_p1, wlo_p1, wreg_p2, whi_p2, wlo_p2;
    logic        wreg_p3, whi_p3, wlo_p3;
    logic [31:0] ex_wdata, hi_q, lo_q, hi_fwd, lo_fwd;

    inst_rom inst_rom0 (.ce(rst), .addr(pc), .inst(rom_inst));

    // ---- IF -> ID boundary
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc     <= 32'h0;
            vld_p0 <= 1'b0;
        end else begin
            pc     <= pc + 32'd4;
            vld_p0 <= 1'b1;
        end
        inst_p0 <= rom_inst;
    end

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] rf_rdata1, rf_rdata2, rs_val, rt_val;
    logic        unused_shamt;

    assign op           = inst_p0[31:26];
    assign rs           = inst_p0[25:21];
    assign rt           = inst_p0[20:16];
    assign rd           = inst_p0[15:11];
    assign funct        = inst_p0[5:0];
    assign imm          = inst_p0[15:0];
    assign unused_shamt = ^inst_p0[10:6];

    // A write that lands while reset is asserted is flushed with the pipeline.
    regfile regfile1 (
        .clk(clk), .we(wreg_p3 & rst), .waddr(wd_p3), .wdata(wdata_p3),
        .raddr1(rs), .rdata1(rf_rdata1), .raddr2(rt), .rdata2(rf_rdata2)
    );

    // Forwarding priority: EX result, then MEM result, then register file.
    // Writes to r0 never carry wreg, so r0 is never forwarded.
    assign rs_val = (wreg_p1 && wd_p1 == rs) ? ex_wdata :
                    (wreg_p2 && wd_p2 == rs) ? wdata_p2 : rf_rdata1;
    assign rt_val = (wreg_p1 && wd_p1 == rt) ? ex_wdata :
                    (wreg_p2 && wd_p2 == rt) ? wdata_p2 : rf_rdata2;

    alu_e        id_alusel;
    logic [31:0] id_opa, id_opb;
    logic [4:0]  id_wd;
    logic        id_wreg, id_whi, id_wlo;

    always_comb begin
        id_alusel = ALU_NOP;
        id_opa    = rs_val;
        id_opb    = rt_val;
        id_wd     = rd;
        id_wreg   = 1'b0;
        id_whi    = 1'b0;
        id_wlo    = 1'b0;
        case (op)
            6'h00: begin
                case (funct)
                    6'h25: begin id_alusel = ALU_OR;  id_wreg = 1'b1; end
                    6'h24: begin id_alusel = ALU_AND; id_wreg = 1'b1; end
                    6'h26: begin id_alusel = ALU_XOR; id_wreg = 1'b1; end
                    6'h27: begin id_alusel = ALU_NOR; id_wreg = 1'b1; end
`ifdef OPENMIPS_MOVE_EN
                    // Move condition is resolved here, where rt is already forwarded.
                    6'h0A: begin id_alusel = ALU_PASS; id_wreg = (rt_val == 32'h0); end
                    6'h0B: begin id_alusel = ALU_PASS; id_wreg = (rt_val != 32'h0); end
                    6'h10: begin id_alusel = ALU_HI;   id_wreg = 1'b1; end
                    6'h12: begin id_alusel = ALU_LO;   id_wreg = 1'b1; end
                    6'h11: id_whi = 1'b1;
                    6'h13: id_wlo = 1'b1;
`endif
                    default: ;
                endcase
            end
            6'h0D: begin id_alusel = ALU_OR;  id_opb = {16'h0, imm}; id_wd = rt; id_wreg = 1'b1; end
            6'h0C: begin id_alusel = ALU_AND; id_opb = {16'h0, imm}; id_wd = rt; id_wreg = 1'b1; end
            6'h0E: begin id_alusel = ALU_XOR; id_opb = {16'h0, imm}; id_wd = rt; id_wreg = 1'b1; end
            6'h0F: begin id_alusel = ALU_PASS; id_opa = {imm, 16'h0}; id_wd = rt; id_wreg = 1'b1; end
            default: ;
        endcase
    end

    // ---- ID -> EX boundary
    always_ff @(posedge clk) begin
        if (!rst) begin
            wreg_p1 <= 1'b0;
            whi_p1  <= 1'b0;
            wlo_p1  <= 1'b0;
        end else begin
            wreg_p1 <= vld_p0 && id_wreg && (id_wd != 5'd0);
            whi_p1  <= vld_p0 && id_whi;
            wlo_p1  <= vld_p0 && id_wlo;
        end
        alusel_p1 <= id_alusel;
        opa_p1    <= id_opa;
        opb_p1    <= id_opb;
        wd_p1     <= id_wd;
    end

    // A pending HI/LO write in MEM wins only if it targets that register.
    assign hi_fwd = whi_p2 ? hilo_p2 : (whi_p3 ? hilo_p3 : hi_q);
    assign lo_fwd = wlo_p2 ? hilo_p2 : (wlo_p3 ? hilo_p3 : lo_q);

    always_comb begin
        ex_wdata = 32'h0;
        case (alusel_p1)
            ALU_OR:   ex_wdata = opa_p1 | opb_p1;
            ALU_AND:  ex_wdata = opa_p1 & opb_p1;
            ALU_XOR:  ex_wdata = opa_p1 ^ opb_p1;
            ALU_NOR:  ex_wdata = ~(opa_p1 | opb_p1);
            ALU_PASS: ex_wdata = opa_p1;
            ALU_HI:   ex_wdata = hi_fwd;
            ALU_LO:   ex_wdata = lo_fwd;
            default:  ex_wdata = 32'h0;
        endcase
    end

    // ---- EX -> MEM boundary
    always_ff @(posedge clk) begin
        if (!rst) begin
            wreg_p2 <= 1'b0;
            whi_p2  <= 1'b0;
            wlo_p2  <= 1'b0;
        end else begin
            wreg_p2 <= wreg_p1;
            whi_p2  <= whi_p1;
            wlo_p2  <= wlo_p1;
        end
        wd_p2    <= wd_p1;
        wdata_p2 <= ex_wdata;
        hilo_p2  <= opa_p1;
    end

    // ---- MEM -> WB boundary
    always_ff @(posedge clk) begin
        if (!rst) begin
            wreg_p3 <= 1'b0;
            whi_p3  <= 1'b0;
            wlo_p3  <= 1'b0;
        end else begin
            wreg_p3 <= wreg_p2;
            whi_p3  <= whi_p2;
            wlo_p3  <= wlo_p2;
        end
        wd_p3    <= wd_p2;
        wdata_p3 <= wdata_p2;
        hilo_p3  <= hilo_p2;
    end

    hilo_reg hilo_reg0 (
        .clk(clk), .rst(rst), .we_hi(whi_p3), .we_lo(wlo_p3),
        .hi_i(hilo_p3), .lo_i(hilo_p3), .hi_o(hi_q), .lo_o(lo_q)
    );
endmodule

module openmips_minimal_sopc (
    input  logic clk,
    input  logic rst
);
    openmips openmips0 (.clk(clk), .rst(rst));
endmodule

// File: tb/tb_openmips_minimal_sopc.sv
module tb_openmips_minimal_sopc;
    logic clk;
    logic rst;

    openmips_minimal_sopc dut (.clk(clk), .rst(rst));

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef OPENMIPS_MOVE_EN
    localparam bit MOVE = 1'b1;
`else
    localparam bit MOVE = 1'b0;
`endif

    localparam int KHI = 32;
    localparam int KLO = 33;

    typedef struct {
        int          edge_n;
        int          kind;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
        logic [4:0] s, t, d;
        logic [5:0] f;
        s = rs[4:0]; t = rt[4:0]; d = rd[4:0]; f = fn[5:0];
        return {6'h00, s, t, d, 5'd0, f};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
        logic [5:0]  o;
        logic [4:0]  s, t;
        logic [15:0] i;
        o = op[5:0]; s = rs[4:0]; t = rt[4:0]; i = imm[15:0];
        return {o, s, t, i};
    endfunction

    function automatic logic [31:0] peek(input int kind);
        if (kind == KHI) return dut.openmips0.hilo_reg0.hi_o;
        else if (kind == KLO) return dut.openmips0.hilo_reg0.lo_o;
        else return dut.openmips0.regfile1.regs[kind[4:0]];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input int e, input int kind, input logic [31:0] v, input string tag);
        exp_t x;
        x.edge_n = e; x.kind = kind; x.val = v; x.tag = tag;
        sb.push_back(x);
    endtask

    // Runs n edges after release, popping every expectation due on each edge.
    task automatic run_edges(input int n);
        exp_t x;
        for (int e = 1; e <= n; e++) begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].edge_n == e) begin
                x = sb.pop_front();
                check(x.tag, peek(x.kind), x.val);
            end
        end
    endtask

    logic [31:0] prog [0:26];

    initial begin
        rst = 1'b0;
        prog[0]  = itype(6'h0D, 0, 1, 16'h0000);   // ori  r1,r0,0
        prog[1]  = itype(6'h0F, 0, 2, 16'hFFFF);   // lui  r2,0xFFFF
        prog[2]  = itype(6'h0F, 0, 3, 16'h0505);   // lui  r3,0x0505
        prog[3]  = itype(6'h0D, 0, 4, 16'h00AA);   // ori  r4,r0,0xAA
        prog[4]  = rtype(2, 1, 4, 6'h0B);          // movn r4,r2,r1
        prog[5]  = rtype(2, 1, 4, 6'h0A);          // movz r4,r2,r1
        prog[6]  = rtype(3, 2, 4, 6'h0B);          // movn r4,r3,r2
        prog[7]  = itype(6'h0F, 0, 5, 16'h1234);   // lui  r5,0x1234
        prog[8]  = itype(6'h0D, 5, 5, 16'h5678);   // ori  r5,r5,0x5678
        prog[9]  = rtype(2, 0, 0, 6'h11);          // mthi r2
        prog[10] = rtype(3, 0, 0, 6'h11);          // mthi r3
        prog[11] = rtype(3, 0, 0, 6'h13);          // mtlo r3
        prog[12] = rtype(2, 0, 0, 6'h13);          // mtlo r2
        prog[13] = rtype(0, 0, 4, 6'h10);          // mfhi r4
        prog[14] = rtype(0, 0, 0, 6'h13);          // mtlo r0
        prog[15] = rtype(0, 0, 4, 6'h12);          // mflo r4
        prog[16] = rtype(3, 0, 0, 6'h13);          // mtlo r3
        prog[17] = 32'h0;                          // nop
        prog[18] = rtype(0, 0, 4, 6'h12);          // mflo r4
        prog[19] = rtype(2, 3, 6, 6'h24);          // and  r6,r2,r3
        prog[20] = rtype(2, 3, 7, 6'h26);          // xor  r7,r2,r3
        prog[21] = rtype(1, 5, 8, 6'h27);          // nor  r8,r1,r5
        prog[22] = itype(6'h0C, 5, 9, 16'hFF0F);   // andi r9,r5,0xFF0F
        prog[23] = itype(6'h0E, 5, 10, 16'hFFFF);  // xori r10,r5,0xFFFF
        prog[24] = itype(6'h3F, 0, 1, 16'h1234);   // undefined opcode
        prog[25] = itype(6'h0D, 0, 0, 16'h0055);   // ori  r0,r0,0x55
        prog[26] = itype(6'h0D, 0, 11, 16'h0001);  // ori  r11,r0,1
        for (int i = 0; i < 1024; i++) dut.openmips0.inst_rom0.inst_mem[i] = 32'h0;
        for (int i = 0; i < 27; i++) dut.openmips0.inst_rom0.inst_mem[i] = prog[i];

        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("reset_hi", peek(KHI), 32'h0);
            check("reset_lo", peek(KLO), 32'h0);
        end

        push(5,  1,   32'h00000000, "r1_ori");
        push(6,  2,   32'hFFFF0000, "r2_lui");
        push(7,  3,   32'h05050000, "r3_lui");
        push(8,  4,   32'h000000AA, "r4_ori");
        push(9,  4,   32'h000000AA, "r4_movn_nowrite");
        push(10, 4,   MOVE ? 32'hFFFF0000 : 32'h000000AA, "r4_movz");
        push(11, 4,   MOVE ? 32'h05050000 : 32'h000000AA, "r4_movn");
        push(12, 5,   32'h12340000, "r5_lui");
        push(13, 5,   32'h12345678, "r5_ex_fwd");
        push(13, KHI, 32'h00000000, "hi_before_mthi");
        push(14, KHI, MOVE ? 32'hFFFF0000 : 32'h0, "hi_mthi_r2");
        push(15, KHI, MOVE ? 32'h05050000 : 32'h0, "hi_mthi_r3");
        push(16, KLO, MOVE ? 32'h05050000 : 32'h0, "lo_mtlo_r3");
        push(17, KLO, MOVE ? 32'hFFFF0000 : 32'h0, "lo_mtlo_r2");
        push(18, 4,   MOVE ? 32'h05050000 : 32'h000000AA, "r4_mfhi");
        push(19, KLO, 32'h00000000, "lo_mtlo_r0");
        push(20, 4,   MOVE ? 32'h00000000 : 32'h000000AA, "r4_mflo_mem_fwd");
        push(21, KLO, MOVE ? 32'h05050000 : 32'h0, "lo_mtlo_r3_again");
        push(23, 4,   MOVE ? 32'h05050000 : 32'h000000AA, "r4_mflo_wb_fwd");
        push(24, 6,   32'h05050000, "r6_and");
        push(25, 7,   32'hFAFA0000, "r7_xor");
        push(26, 8,   32'hEDCBA987, "r8_nor");
        push(27, 9,   32'h00005608, "r9_andi");
        push(28, 10,  32'h1234A987, "r10_xori");
        push(29, 1,   32'h00000000, "r1_undef_nop");
        push(31, 11,  32'h00000001, "r11_r0_reads_zero");

        rst = 1'b1;
        run_edges(36);
        check("sb_drained_run1", sb.size(), 0);

        // Mid-program reset: pipeline flushed, registers retained, HI/LO cleared.
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst2_hi", peek(KHI), 32'h0);
        check("rst2_lo", peek(KLO), 32'h0);
        check("rst2_r5_kept", peek(5), 32'h12345678);
        check("rst2_r11_kept", peek(11), 32'h00000001);

        push(7, 4, MOVE ? 32'h05050000 : 32'h000000AA, "restart_r4_before");
        push(8, 4, 32'h000000AA, "restart_r4_ori");
        push(8, 5, 32'h12345678, "restart_r5_kept");
        rst = 1'b1;
        run_edges(10);
        check("sb_drained_run2", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/openmips_minimal_sopc.md
# openmips_minimal_sopc

Minimal MIPS32 system-on-programmable-chip: a 5-stage in-order integer pipeline with a private instruction ROM, a 32x32 register file and HI/LO registers. It is the top level used for instruction-class simulation. Programs are preloaded into the ROM by backdoor, and results are checked by peeking internal state. There is no data memory and there are no external buses.

## Interface
- No parameters.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset, synchronous, active-low (0 = reset).
- Backdoor-visible hierarchy, which must be kept exactly:
  - `openmips0.inst_rom0.inst_mem`: word array, at least 16 entries of 32 bits, indexed by PC[31:2].
  - `openmips0.regfile1.regs[0:31]`: register file, 32 bits per entry.
  - `openmips0.hilo_reg0.hi_o` and `openmips0.hilo_reg0.lo_o`: HI and LO, 32 bits each.

## Operation
- Stages:
  - IF: PC register and ROM read.
  - ID: decode, register read and forwarding.
  - EX: ALU and move selection.
  - MEM: pass-through.
  - WB: register file and HI/LO write.
  - Each stage boundary is a pipeline register.
- PC increments by 4 every cycle. There are no branches, stalls or exceptions.
- Supported instructions:
  - Logical: `or`, `and`, `xor`, `nor`, `ori`, `andi`, `xori`, `lui`, with zero-extended immediates.
  - Moves: `movn`, `movz`, `mfhi`, `mflo`, `mthi`, `mtlo`.
  - `sll 0,0,0` (nop).
  - Any other encoding executes as a nop: no register, HI or LO write.
- `movz rd,rs,rt` writes rs to rd only if rt==0. `movn rd,rs,rt` writes only if rt!=0. When the condition fails, the write enable is cleared and rd is unchanged.
- `mfhi`/`mflo` write HI/LO to rd. `mthi`/`mtlo` write rs to HI/LO only, not to the register file.
- Register r0 always reads 0 and writes to it are discarded. Other registers are uninitialised (X) after reset; reset does not clear them.
- HI/LO reset to 0x00000000.
- Forwarding, with priority EX result > MEM result > register file:
  - Applies to rs and rt reads in ID.
  - A WB write and an ID read of the same register in the same cycle returns the new value (write-through).
- HI/LO forwarding:
  - `mfhi`/`mflo` in EX takes a pending HI/LO value from MEM, then from WB, then from the register.
  - The MEM value is selected only when the pending move in MEM targets that register.
- Back-to-back dependent instructions execute with no bubbles.

## Timing
- While `rst`=0:
  - PC = 0 and the ROM output is forced to 0 (nop).
  - All pipeline registers hold nop (write enables 0).
  - HI = LO = 0.
- The first clock edge sampling `rst`=1 loads the first fetch of address 0.
- Instruction k (word index) updates the register file or HI/LO on rising edge k+5 after reset release.
- After that, results commit one instruction per cycle.
- Applying reset mid-program flushes the pipeline on the sampling edge. Register contents are retained and execution restarts at address 0.

## Configuration
- Macro `OPENMIPS_MOVE_EN`.
  - Defined: `movn`, `movz`, `mfhi`, `mflo`, `mthi`, `mtlo` execute as described, including HI/LO forwarding.
  - Undefined: these six decode as nop. HI/LO remain at 0 after reset. The logical instructions are unaffected.

## Test plan
- Reset: hold `rst`=0 for 10 cycles, then release.
  - HI=LO=0 throughout.
  - No register changes until edge 5 after release.
- Basic writes: program `ori r1,r0,0`; `lui r2,0xFFFF`; `lui r3,0x0505`.
  - r1=0x00000000 at edge 5, r2=0xFFFF0000 at edge 6, r3=0x05050000 at edge 7.
  - All three rely on forwarding-free independent writes.
- Conditional moves: continue with `movn r4,r2,r1` (no write) → `movz r4,r2,r1` → `movn r4,r3,r2`.
  - r4 stays X, then becomes 0xFFFF0000, then 0x05050000 on consecutive commits.
- Dependent back-to-back: `lui r5,0x1234` then `ori r5,r5,0x5678`.
  - r5=0x12345678 with no stall, via EX forwarding.
- HI/LO:
  - `mthi r2`; `mthi r3`: HI goes 0xFFFF0000, then 0x05050000.
  - `mtlo r3`; `mtlo r2`: LO goes 0x05050000, then 0xFFFF0000.
  - `mtlo r0`: LO=0.
  - `mfhi r4` immediately after: r4=0x05050000.
  - `mflo r4` immediately after `mtlo r0`: r4=0x00000000, via MEM/WB HI/LO forwarding.
- Build without `OPENMIPS_MOVE_EN`: the same move program leaves r4=X and HI=LO=0, while r1–r3 are unchanged from the Basic writes scenario.
